// File: rtl/mod_counter_pkg.sv
// Shared constants and the pure next-count function for the modulo step counter.
// The prescaler is enabled by defining MOD_COUNTER_PRESCALE_EN.
package mod_counter_pkg;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Operands are zero-extended to 32 bits; result is {evt, cnt_next}.
  // s must already be clamped to modulus-1 by the caller.
  function automatic logic [32:0] next_count(
    input logic [31:0] cnt,
    input logic [31:0] s,
    input logic        dir,
    input logic        sat,
    input logic [31:0] modulus
  );
    logic [32:0] sum;
    logic [31:0] nxt;
    logic        evt;
    sum = {1'b0, cnt} + {1'b0, s};
    nxt = cnt;
    evt = 1'b0;
    if (dir == DIR_UP) begin
      if (sum < {1'b0, modulus}) begin
        nxt = sum[31:0];
      end else begin
        evt = 1'b1;
        nxt = (sat == MODE_SAT) ? (modulus - 32'd1) : (sum[31:0] - modulus);
      end
    end else begin
      if (s <= cnt) begin
        nxt = cnt - s;
      end else begin
        evt = 1'b1;
        nxt = (sat == MODE_SAT) ? 32'd0 : (cnt + modulus - s);
      end
    end
    return {evt, nxt};
  endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// Enable prescaler: tick is asserted on every PRESCALE-th cycle with en = 1.
// Only instantiated when MOD_COUNTER_PRESCALE_EN is defined.
module mod_counter_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = $clog2(PRESCALE) + 1;

  logic [PW-1:0] count_reg;

  assign tick = en && (count_reg == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= tick ? '0 : count_reg + PW'(1);
    end
  end

endmodule

// File: rtl/mod_step_counter.sv
// Modulo-N up/down counter with runtime step, load, wrap/saturate mode and event pulse.
// Define MOD_COUNTER_PRESCALE_EN to advance only on every PRESCALE-th enable.
module mod_step_counter
  import mod_counter_pkg::*;
#(
  parameter int MODULUS  = 10,
  parameter int STEP_W   = 4,
  parameter int PRESCALE = 4,
  localparam int CNT_W   = $clog2(MODULUS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              dir,
  input  logic              sat_mode,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_val,
  output logic [CNT_W-1:0]  cnt,
  output logic              evt,
  output logic              at_max,
  output logic              at_min
);

  localparam logic [31:0]      MAX_VAL = 32'(MODULUS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MODULUS - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             evt_reg;
  logic [31:0]      step_ext;
  logic [31:0]      s_clamped;
  logic [31:0]      load_ext;
  logic [CNT_W-1:0] load_clamped;
  logic [32:0]      step_result;
  logic             advance;
  logic             unused_bits;

  assign step_ext     = 32'(step);
  assign s_clamped    = (step_ext > MAX_VAL) ? MAX_VAL : step_ext;
  assign load_ext     = 32'(load_val);
  assign load_clamped = (load_ext > MAX_VAL) ? MAX_CNT : load_val;
  assign step_result  = next_count(32'(cnt_reg), s_clamped, dir, sat_mode, 32'(MODULUS));
  assign unused_bits  = ^step_result[31:CNT_W];

`ifdef MOD_COUNTER_PRESCALE_EN
  logic tick;

  mod_counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (load),
    .en    (en),
    .tick  (tick)
  );

  assign advance = tick;
`else
  localparam int unused_prescale = PRESCALE;
  assign advance = en;
`endif

  // Load outranks enable; an idle cycle always clears the event pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
      evt_reg <= 1'b0;
    end else if (load) begin
      cnt_reg <= load_clamped;
      evt_reg <= 1'b0;
    end else if (advance) begin
      cnt_reg <= step_result[CNT_W-1:0];
      evt_reg <= step_result[32];
    end else begin
      evt_reg <= 1'b0;
    end
  end

  assign cnt    = cnt_reg;
  assign evt    = evt_reg;
  assign at_max = (cnt_reg == MAX_CNT);
  assign at_min = (cnt_reg == '0);

endmodule
